// File: rtl/basilisk_writeback_arbiter_if.sv
// Writeback bus between the functional-unit result streams, the register-file
// write port and the issue-stage completion signals.
interface basilisk_writeback_arbiter_if #(
  parameter int PORTS  = 6,
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
);
  localparam int REC_W = 5 + OFF_W + DATA_W;

  logic [PORTS-1:0]            in_valid;
  logic [PORTS-1:0]            in_ready;
  logic [PORTS-1:0][REC_W-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [REC_W-1:0]            out_data;
  logic                        done_valid;
  logic [4:0]                  done_reg_addr;
  logic                        dup_error;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, done_valid, done_reg_addr, dup_error
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, done_valid, done_reg_addr, dup_error
  );
endinterface

// File: rtl/basilisk_writeback_arbiter.sv
// Round-robin merge of functional-unit results into the vector register file
// write port, with per-register slice completion tracking.
module basilisk_writeback_arbiter #(
  parameter int PORTS        = 6,
  parameter int DATA_W       = 32,
  parameter int OFF_W        = 2,
  parameter int OFFSET_COUNT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  basilisk_writeback_arbiter_if.slave  wb
);
  localparam int REC_W = 5 + OFF_W + DATA_W;
  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        grant_idx;
  logic [PORTS-1:0]        grant_oh;
  logic                    any_valid;
  logic                    load;
  logic                    commit;

  logic                    out_valid_p1;
  logic [REC_W-1:0]        out_data_p1;
  logic                    done_valid_p2;
  logic [4:0]              done_reg_p2;
  logic                    dup_error_q;
  logic [OFFSET_COUNT-1:0] mask [32];

  logic [4:0]              c_reg;
  logic [OFF_W-1:0]        c_off;
  logic                    c_off_ok;
  logic [OFFSET_COUNT-1:0] c_onehot;
  logic [OFFSET_COUNT-1:0] c_merged;
  logic                    c_hit;
  logic                    c_full;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= PORTS) s = s - PORTS;
    return PTR_W'(s);
  endfunction

  // Search upward from rr_ptr, wrapping, for the first valid producer.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = rr_ptr;
    grant_oh  = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!any_valid && wb.in_valid[ptr_add(rr_ptr, k)]) begin
        any_valid = 1'b1;
        grant_idx = ptr_add(rr_ptr, k);
      end
    end
    if (any_valid) grant_oh[grant_idx] = 1'b1;
  end

  assign load        = !out_valid_p1 || wb.out_ready;
  assign commit      = out_valid_p1 && wb.out_ready;
  assign wb.in_ready = load ? grant_oh : '0;

  // Stage p1: registered write-port output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_p1 <= 1'b0;
      out_data_p1  <= '0;
      rr_ptr       <= '0;
    end else if (load) begin
      if (any_valid) begin
        out_valid_p1 <= 1'b1;
        out_data_p1  <= wb.in_data[grant_idx];
        rr_ptr       <= ptr_add(grant_idx, 1);
      end else begin
        out_valid_p1 <= 1'b0;
      end
    end
  end

  assign c_reg    = out_data_p1[REC_W-1 -: 5];
  assign c_off    = out_data_p1[DATA_W +: OFF_W];
  assign c_off_ok = int'(c_off) < OFFSET_COUNT;
  assign c_onehot = OFFSET_COUNT'(1'b1) << c_off;
  assign c_hit    = |(mask[c_reg] & c_onehot);
  assign c_merged = mask[c_reg] | c_onehot;
  assign c_full   = &c_merged;

  // Stage p2: slice completion tracking on write commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) mask[r] <= '0;
      done_valid_p2 <= 1'b0;
      done_reg_p2   <= '0;
      dup_error_q   <= 1'b0;
    end else begin
      done_valid_p2 <= 1'b0;
      if (commit) begin
        if (!c_off_ok || c_hit) begin
          dup_error_q <= 1'b1;
        end else if (c_full) begin
          mask[c_reg]   <= '0;
          done_valid_p2 <= 1'b1;
          done_reg_p2   <= c_reg;
        end else begin
          mask[c_reg] <= c_merged;
        end
      end
    end
  end

  assign wb.out_valid     = out_valid_p1;
  assign wb.out_data      = out_data_p1;
  assign wb.done_valid    = done_valid_p2;
  assign wb.done_reg_addr = done_reg_p2;
  assign wb.dup_error     = dup_error_q;
endmodule

// File: tb/tb_basilisk_writeback_arbiter.sv
// Scoreboard bench for basilisk_writeback_arbiter: arbitration order,
// backpressure, completion pulses, duplicate detection and async reset.
module tb_basilisk_writeback_arbiter;
  localparam int PORTS  = 6;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 2;
  localparam int REC_W  = 5 + OFF_W + DATA_W;

  logic clk = 1'b0;
  logic rst;

  basilisk_writeback_arbiter_if #(.PORTS(PORTS), .DATA_W(DATA_W), .OFF_W(OFF_W)) wb ();

  basilisk_writeback_arbiter #(
    .PORTS(PORTS), .DATA_W(DATA_W), .OFF_W(OFF_W), .OFFSET_COUNT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               port;
    logic [REC_W-1:0] rec;
  } pend_t;

  int               total = 0;
  int               bad   = 0;
  pend_t            pend_q[$];
  logic [REC_W-1:0] exp_q[$];
  int               grant_log[$];
  int               done_log[$];

  int         m_rr;
  bit         m_ov;
  bit         m_done;
  logic [4:0] m_done_reg;
  bit         m_dup;
  logic [1:0] m_mask [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input logic [4:0] r, input logic [1:0] o,
                                           input logic [31:0] v);
    return {r, o, v};
  endfunction

  function automatic bit port_has(input int p);
    foreach (pend_q[j]) if (pend_q[j].port == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int p, input logic [REC_W-1:0] rec);
    pend_t e;
    e.port = p;
    e.rec  = rec;
    pend_q.push_back(e);
  endtask

  task automatic pop_port(input int p, output logic [REC_W-1:0] rec);
    int idx;
    idx = -1;
    rec = '0;
    foreach (pend_q[j]) if (idx < 0 && pend_q[j].port == p) idx = j;
    if (idx >= 0) begin
      rec = pend_q[idx].rec;
      pend_q.delete(idx);
    end
  endtask

  task automatic drive();
    bit found;
    wb.in_valid = '0;
    wb.in_data  = '0;
    for (int i = 0; i < PORTS; i++) begin
      found = 1'b0;
      foreach (pend_q[j]) begin
        if (!found && pend_q[j].port == i) begin
          found          = 1'b1;
          wb.in_valid[i] = 1'b1;
          wb.in_data[i]  = pend_q[j].rec;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_rr       = 0;
    m_ov       = 1'b0;
    m_done     = 1'b0;
    m_done_reg = '0;
    m_dup      = 1'b0;
    for (int r = 0; r < 32; r++) m_mask[r] = 2'b00;
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic model_commit(input logic [REC_W-1:0] rec);
    logic [4:0] r;
    logic [1:0] o;
    r = rec[REC_W-1 -: 5];
    o = rec[DATA_W +: 2];
    if (o >= 2'd2 || m_mask[r][o[0]]) begin
      m_dup = 1'b1;
    end else begin
      m_mask[r][o[0]] = 1'b1;
      if (m_mask[r] == 2'b11) begin
        m_mask[r]  = 2'b00;
        m_done     = 1'b1;
        m_done_reg = r;
      end
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model.
  task automatic cycle();
    int               eg;
    int               p;
    int               gi;
    bit               load;
    logic [5:0]       er;
    logic [REC_W-1:0] rec;
    drive();
    @(negedge clk);
    load = !m_ov || wb.out_ready;
    eg   = -1;
    for (int k = 0; k < PORTS; k++) begin
      p = (m_rr + k) % PORTS;
      if (eg < 0 && port_has(p)) eg = p;
    end
    er = '0;
    if (load && eg >= 0) er[eg] = 1'b1;
    chk("in_ready", 64'(wb.in_ready), 64'(er));
    chk("out_valid", 64'(wb.out_valid), 64'(m_ov));
    chk("done_valid", 64'(wb.done_valid), 64'(m_done));
    if (m_done) chk("done_reg", 64'(wb.done_reg_addr), 64'(m_done_reg));
    chk("dup_error", 64'(wb.dup_error), 64'(m_dup));
    if (wb.done_valid) done_log.push_back(int'(wb.done_reg_addr));
    gi = -1;
    for (int i = 0; i < PORTS; i++) if (wb.in_ready[i]) gi = i;
    if (gi >= 0) grant_log.push_back(gi);

    m_done = 1'b0;
    if (m_ov && wb.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 64'(1), 64'(0));
      end else begin
        rec = exp_q.pop_front();
        chk("out_data", 64'(wb.out_data), 64'(rec));
        model_commit(rec);
      end
    end
    if (load) begin
      if (eg >= 0) begin
        pop_port(eg, rec);
        exp_q.push_back(rec);
        m_rr = (eg + 1) % PORTS;
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    drive();
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    wb.out_ready = 1'b0;
    model_reset();
    drive();
    #12;
    chk("rst_out_valid", 64'(wb.out_valid), 64'(0));
    chk("rst_out_data", 64'(wb.out_data), 64'(0));
    chk("rst_done", 64'(wb.done_valid), 64'(0));
    chk("rst_done_reg", 64'(wb.done_reg_addr), 64'(0));
    chk("rst_dup", 64'(wb.dup_error), 64'(0));
    chk("rst_in_ready", 64'(wb.in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single producer filling both slices of reg 7.
    wb.out_ready = 1'b1;
    done_log.delete();
    push(1, mk(5'd7, 2'd0, 32'h3F80_0000));
    push(1, mk(5'd7, 2'd1, 32'h4000_0000));
    repeat (6) cycle();
    chk("t1_done_cnt", 64'(done_log.size()), 64'(1));
    if (done_log.size() > 0) chk("t1_done_reg", 64'(done_log[0]), 64'(7));

    // All ports valid continuously.
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < PORTS; i++)
        push(i, mk(5'(16 + i), 2'(k % 2), 32'(i * 256 + k)));
    grant_log.delete();
    repeat (40) cycle();
    chk("rr_count", 64'(grant_log.size()), 64'(36));
    for (int k = 1; k < grant_log.size(); k++)
      chk("rr_seq", 64'(grant_log[k]), 64'((grant_log[k-1] + 1) % PORTS));

    // Backpressure with ports 2 and 4 valid.
    wb.out_ready = 1'b0;
    push(2, mk(5'd2, 2'd0, 32'h0000_AAAA));
    cycle();
    push(4, mk(5'd4, 2'd0, 32'h0000_BBBB));
    repeat (5) begin
      cycle();
      chk("stall_data", 64'(wb.out_data), 64'(mk(5'd2, 2'd0, 32'h0000_AAAA)));
      chk("stall_ready", 64'(wb.in_ready), 64'(0));
    end
    wb.out_ready = 1'b1;
    repeat (4) cycle();
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Interleaved registers complete in order 9 then 5.
    done_log.delete();
    push(0, mk(5'd5, 2'd0, 32'h1));
    push(0, mk(5'd9, 2'd0, 32'h2));
    push(0, mk(5'd9, 2'd1, 32'h3));
    push(0, mk(5'd5, 2'd1, 32'h4));
    repeat (7) cycle();
    chk("il_cnt", 64'(done_log.size()), 64'(2));
    if (done_log.size() == 2) begin
      chk("il_first", 64'(done_log[0]), 64'(9));
      chk("il_second", 64'(done_log[1]), 64'(5));
    end

    // Async reset while stalled with reg 12 half written.
    push(0, mk(5'd12, 2'd0, 32'hC0));
    repeat (3) cycle();
    wb.out_ready = 1'b0;
    push(3, mk(5'd13, 2'd0, 32'hD0));
    repeat (3) cycle();
    chk("pre_rst_valid", 64'(wb.out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(wb.out_valid), 64'(0));
    chk("arst_out_data", 64'(wb.out_data), 64'(0));
    chk("arst_done", 64'(wb.done_valid), 64'(0));
    model_reset();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wb.out_ready = 1'b1;
    done_log.delete();
    push(1, mk(5'd12, 2'd1, 32'hC1));
    repeat (4) cycle();
    chk("arst_no_done", 64'(done_log.size()), 64'(0));

    // Out-of-range offset flags an error but still commits.
    push(5, mk(5'd20, 2'd2, 32'hE0));
    repeat (3) cycle();
    chk("oor_dup", 64'(wb.dup_error), 64'(1));

    // Duplicate slice, then completion of the same register.
    pulse_reset();
    wb.out_ready = 1'b1;
    done_log.delete();
    push(0, mk(5'd3, 2'd0, 32'h30));
    push(0, mk(5'd3, 2'd0, 32'h31));
    push(0, mk(5'd3, 2'd1, 32'h32));
    repeat (6) cycle();
    chk("dup_sticky", 64'(wb.dup_error), 64'(1));
    chk("dup_done_cnt", 64'(done_log.size()), 64'(1));
    if (done_log.size() > 0) chk("dup_done_reg", 64'(done_log[0]), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
